// File: rtl/config_mac_accum.sv
// Streaming multiply-accumulate back end: sums signed 17-bit product beats into a
// saturating ACCW-bit accumulator and holds each completed vector until it is consumed.
module config_mac_accum #(
  parameter int ACCW     = 24,
  parameter int MAXBEATS = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16:0]     in_product,
  input  logic            in_last,
  input  logic [1:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_acc,
  output logic [7:0]      out_count,
  output logic [1:0]      out_mode,
  output logic            out_sat
);

  // state  | meaning
  // S_IDLE | waiting for the first beat of a vector
  // S_ACC  | accumulating beats of the current vector
  // S_DONE | result held until the consumer takes it
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic [7:0]      MAXB    = 8'(MAXBEATS);

  state_t          state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [7:0]      count_q, count_d;
  logic [1:0]      mode_q, mode_d;
  logic            sat_q, sat_d;
  logic            out_valid_q;

  logic            accept;
  logic [ACCW:0]   prod_ext;
  logic [ACCW:0]   sum;
  logic            clamp;
  logic [ACCW-1:0] sum_sat;
  logic [7:0]      count_inc;

  // Reset gates in_ready directly so no beat looks accepted while reset is held.
  assign in_ready  = !reset && (state_q != S_DONE);
  assign accept    = in_valid && in_ready;

  assign prod_ext  = {{(ACCW-16){in_product[16]}}, in_product};
  assign sum       = {acc_q[ACCW-1], acc_q} + prod_ext;
  assign clamp     = sum[ACCW] ^ sum[ACCW-1];
  assign sum_sat   = clamp ? (sum[ACCW] ? ACC_MIN : ACC_MAX) : sum[ACCW-1:0];
  assign count_inc = count_q + 8'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = prod_ext[ACCW-1:0];
          count_d = 8'd1;
          mode_d  = mode;
          sat_d   = 1'b0;
          state_d = (in_last || (MAXB == 8'd1)) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_d   = sum_sat;
          count_d = count_inc;
          sat_d   = sat_q | clamp;
          state_d = (in_last || (count_inc == MAXB)) ? S_DONE : S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      sat_q       <= sat_d;
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign out_mode  = mode_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_config_mac_accum.sv
// Directed and randomized vectors against a saturating-sum reference model.
module tb_config_mac_accum;

  localparam int W    = 18;
  localparam int MAXB = 255;
  localparam longint AMAX = (64'sd1 <<< (W-1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (W-1));

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [16:0]  in_product;
  logic         in_last;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_acc;
  logic [7:0]   out_count;
  logic [1:0]   out_mode;
  logic         out_sat;

  int errors = 0;
  int checks = 0;

  int         vp[$];
  bit         vl[$];
  logic [1:0] vm[$];

  config_mac_accum #(.ACCW(W), .MAXBEATS(MAXB)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_count  (out_count),
    .out_mode   (out_mode),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint acc_s();
    return longint'($signed(out_acc));
  endfunction

  // Sends the queued vector, checks running and final values against the model,
  // optionally holds the result for 'hold' cycles with beats offered, then drains it.
  task automatic run_vector(input bit rdy, input int hold, input bit gaps);
    longint     exp_acc = 0;
    longint     s;
    int         exp_cnt = 0;
    bit         exp_sat = 0;
    logic [1:0] exp_mode = 2'b00;
    bit         done = 0;
    int         waited;
    logic [16:0] p17;
    out_ready = rdy;
    for (int i = 0; i < vp.size(); i++) begin
      if (done) break;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        chk("gap_acc", acc_s(), exp_acc);
        chk("gap_count", longint'(out_count), longint'(exp_cnt));
      end
      p17        = vp[i][16:0];
      in_product = p17;
      in_last    = vl[i];
      mode       = vm[i];
      in_valid   = 1'b1;
      waited = 0;
      while (!in_ready && waited < 20) begin
        @(posedge clk);
        #1;
        waited++;
      end
      chk("ready_wait", longint'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      mode     = 2'($urandom_range(0, 3));
      if (i == 0) begin
        exp_acc  = vp[i];
        exp_cnt  = 1;
        exp_mode = vm[i];
        exp_sat  = 0;
      end else begin
        s = exp_acc + vp[i];
        if (s > AMAX) begin
          exp_acc = AMAX;
          exp_sat = 1;
        end else if (s < AMIN) begin
          exp_acc = AMIN;
          exp_sat = 1;
        end else begin
          exp_acc = s;
        end
        exp_cnt++;
      end
      done = vl[i] || (exp_cnt == MAXB);
      chk("beat_valid", longint'(out_valid), longint'(done));
      chk("beat_acc", acc_s(), exp_acc);
      chk("beat_count", longint'(out_count), longint'(exp_cnt));
    end
    chk("vector_done", longint'(done), 1);
    chk("done_mode", longint'(out_mode), longint'(exp_mode));
    chk("done_sat", longint'(out_sat), longint'(exp_sat));
    chk("done_ready", longint'(in_ready), 0);
    if (!rdy) begin
      in_valid = 1'b1;
      repeat (hold) begin
        in_product = 17'($urandom_range(0, 131071));
        in_last    = 1'($urandom_range(0, 1));
        mode       = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_ready", longint'(in_ready), 0);
        chk("hold_acc", acc_s(), exp_acc);
        chk("hold_count", longint'(out_count), longint'(exp_cnt));
        chk("hold_mode", longint'(out_mode), longint'(exp_mode));
        chk("hold_sat", longint'(out_sat), longint'(exp_sat));
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain_valid", longint'(out_valid), 0);
    chk("drain_ready", longint'(in_ready), 1);
    chk("drain_acc", acc_s(), 0);
    chk("drain_count", longint'(out_count), 0);
    chk("drain_sat", longint'(out_sat), 0);
  endtask

  task automatic set_vec1(input int p, input bit l, input logic [1:0] m);
    vp.push_back(p);
    vl.push_back(l);
    vm.push_back(m);
  endtask

  task automatic clear_vec();
    vp.delete();
    vl.delete();
    vm.delete();
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_product = '0;
    in_last    = 1'b0;
    mode       = 2'b00;
    out_ready  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_ready", longint'(in_ready), 0);
    chk("rst_acc", acc_s(), 0);
    chk("rst_count", longint'(out_count), 0);
    chk("rst_mode", longint'(out_mode), 0);
    chk("rst_sat", longint'(out_sat), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", longint'(in_ready), 1);

    // +5, -3, +7 in mode 01 with the consumer always ready
    clear_vec();
    set_vec1(5, 0, 2'b01);
    set_vec1(-3, 0, 2'b10);
    set_vec1(7, 1, 2'b11);
    run_vector(1'b1, 0, 1'b0);

    // Positive saturation at 18 bits
    clear_vec();
    set_vec1(65535, 0, 2'b00);
    set_vec1(65535, 0, 2'b00);
    set_vec1(2, 1, 2'b00);
    run_vector(1'b1, 0, 1'b0);

    // Back-pressure: result held 10 cycles with beats offered
    clear_vec();
    set_vec1(-65536, 0, 2'b10);
    set_vec1(-65536, 0, 2'b01);
    set_vec1(-1, 1, 2'b00);
    run_vector(1'b0, 10, 1'b0);

    // Mode latched on first beat only
    clear_vec();
    set_vec1(1000, 0, 2'b10);
    set_vec1(-2000, 1, 2'b00);
    run_vector(1'b0, 2, 1'b0);

    // Reserved mode still accumulates
    clear_vec();
    set_vec1(-40000, 1, 2'b11);
    run_vector(1'b0, 1, 1'b0);

    // MAXBEATS boundary: 255 beats with no last flag, 256th offered during DONE
    clear_vec();
    for (int i = 0; i < 256; i++) set_vec1(1, 0, 2'b01);
    run_vector(1'b0, 3, 1'b0);

    // Asynchronous reset mid-vector discards the partial sum
    in_product = 17'd100;
    mode       = 2'b01;
    in_valid   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_count", longint'(out_count), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", longint'(in_ready), 0);
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_acc", acc_s(), 0);
    chk("mid_rst_count", longint'(out_count), 0);
    chk("mid_rst_mode", longint'(out_mode), 0);
    #1;
    reset = 1'b0;
    clear_vec();
    set_vec1(4, 1, 2'b00);
    run_vector(1'b1, 0, 1'b0);

    // Randomized vectors with idle gaps and random back-pressure
    for (int v = 0; v < 12; v++) begin
      clear_vec();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++)
        set_vec1(int'($urandom_range(0, 131071)) - 65536, (i == n - 1),
                 2'($urandom_range(0, 3)));
      run_vector(1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_mac_accum.md
CONFIG_MAC_ACCUM -- requirements
Module: config_mac_accum

Interface
REQ-001 Parameter ACCW, default 24, SHALL set the accumulator width in bits; legal range 18..32.
REQ-002 Parameter MAXBEATS, default 255, SHALL set the maximum number of beats per vector; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that a product beat is present.
REQ-006 in_ready  output  1  SHALL indicate that the block can accept a beat.
REQ-007 in_product  input  17  SHALL carry the multiplier result, interpreted as a two's-complement value.
REQ-008 in_last  input  1  SHALL mark the final beat of a vector.
REQ-009 mode  input  2  SHALL give the precision mode: 00 lo, 01 med, 10 hi, 11 reserved.
REQ-010 out_valid  output  1  SHALL indicate that a completed result is held.
REQ-011 out_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-012 out_acc  output  ACCW  SHALL carry the signed accumulated sum.
REQ-013 out_count  output  8  SHALL carry the number of beats accumulated.
REQ-014 out_mode  output  2  SHALL carry the mode latched on the vector's first beat.
REQ-015 out_sat  output  1  SHALL be a sticky flag, set if any addition in the vector saturated.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-018 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-019 An accepted beat SHALL be sign-extended from 17 bits to ACCW+1 bits before it is added.
REQ-020 On an accepted beat in IDLE:
- acc SHALL take the sign-extended product;
- count SHALL become 1;
- the mode SHALL be latched;
- sat SHALL be cleared;
- the state SHALL go to ACC, or to DONE if the beat is the last one.
REQ-021 On an accepted beat in ACC:
- acc SHALL take the saturated value of acc plus the product;
- count SHALL increment by 1.
REQ-022 Saturation SHALL compute the sum at ACCW+1 bits, clamp it to [-2^(ACCW-1), 2^(ACCW-1)-1], and set sat on clamp.
REQ-023 A vector SHALL complete (go to DONE) on the beat with in_last=1, or on the beat that makes count equal MAXBEATS, whichever comes first.
REQ-024 The mode input SHALL be ignored on every beat except a vector's first beat.
REQ-025 A vector whose latched mode is 11 SHALL still accumulate normally and SHALL report out_mode=11.
REQ-026 out_valid SHALL be registered and SHALL be 1 exactly while the state is DONE.
REQ-027 out_valid SHALL rise in the cycle after the completing beat is accepted (latency 1).
REQ-028 While out_valid=1, out_acc, out_count, out_mode and out_sat SHALL stay stable.
REQ-029 In DONE with out_ready=1, the next state SHALL be IDLE, and acc, count and sat SHALL clear to 0.
REQ-030 Consecutive vectors SHALL be separated by a minimum one-cycle bubble; a beat offered while in DONE SHALL NOT be accepted.
REQ-031 In IDLE and ACC, out_acc, out_count and out_sat SHALL show the running values, but SHALL be qualified only by out_valid.
REQ-032 in_valid=0 in ACC SHALL hold all state; there SHALL be no timeout.

Reset
REQ-033 While reset=1, the block SHALL hold state IDLE, acc=0, count=0, out_mode=00 and out_sat=0.
REQ-034 While reset=1, out_valid SHALL be 0 and in_ready SHALL be 0, regardless of clk.
REQ-035 If reset asserts mid-vector or in DONE, the partial or held result SHALL be discarded with no output.
REQ-036 After reset deasserts, the first accepted beat SHALL start a new vector from 0.

Verification
REQ-037 With mode=01, send beats +5, -3, +7 (the last with in_last=1) and hold out_ready=1 -> out_valid=1 in the cycle after the third beat, out_acc=9, out_count=3, out_mode=01, out_sat=0, then IDLE.
REQ-038 With ACCW=18, send beats 65535, 65535, 2 (last) -> out_acc=131071, out_sat=1, out_count=3.
REQ-039 Complete a vector, hold out_ready=0 for 10 cycles and drive in_valid=1 throughout -> out_valid and all outputs stay stable, in_ready=0, no beat is accepted; raise out_ready -> IDLE on the next cycle.
REQ-040 With MAXBEATS=255, send 255 beats of +1 with in_last=0 -> DONE after the 255th beat, out_acc=255, out_count=255; the 256th beat is not accepted until DONE clears.
REQ-041 Send 2 beats of +100, pulse reset asynchronously between clock edges, then send one beat of +4 (last) -> outputs are 0 and in_ready=0 during reset; result is out_acc=4, out_count=1.
REQ-042 Send a first beat with mode=10 and a second beat (last) with mode=00 -> out_mode=10.
